// File: rtl/microseq_ctrl_if.sv
// rtl/microseq_ctrl_if.sv - microsequencer control/status bundle
//
// Groups the control-register fields, decoder entry address and status
// inputs with the sequencer outputs.
//   master: drives stall, ns, cond_sel, inv, cr_addr, dec_addr, moc, cond_in;
//           observes index, mem_fault, stack_err, depth
//   slave : the sequencer side (microseq_ctrl)
interface microseq_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              stall;
  logic [2:0]        ns;
  logic [2:0]        cond_sel;
  logic              inv;
  logic [ADDR_W-1:0] cr_addr;
  logic [ADDR_W-1:0] dec_addr;
  logic              moc;
  logic [5:0]        cond_in;    // {V,C,N,Z,cond_pass,moc_alt} for cond_sel 6..1
  logic [ADDR_W-1:0] index;
  logic              mem_fault;
  logic              stack_err;
  logic [3:0]        depth;

  modport master (
    output stall, ns, cond_sel, inv, cr_addr, dec_addr, moc, cond_in,
    input  index, mem_fault, stack_err, depth
  );

  modport slave (
    input  stall, ns, cond_sel, inv, cr_addr, dec_addr, moc, cond_in,
    output index, mem_fault, stack_err, depth
  );
endinterface

// File: rtl/microseq_ctrl.sv
// rtl/microseq_ctrl.sv - microstore address sequencer
//
// Produces the registered microstore index each cycle from the current
// microinstruction's next-state mode, the decoder entry address and the
// selected condition. Modes: decode, fetch, increment, conditional branch,
// jump, call, return, memory wait (with timeout to FAULT_ADDR).
//
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - microseq_ctrl_if.slave (control fields in; index, mem_fault,
//             stack_err, depth out)
//
// Build option: MICROSEQ_RETURN_STACK_EN enables the return stack. Without
// it, call acts as jump, return acts as fetch, depth is 0, stack_err is 0.
module microseq_ctrl #(
  parameter int                ADDR_W     = 7,
  parameter int                TIMEOUT    = 15,
  parameter logic [ADDR_W-1:0] FAULT_ADDR = 7'h60,
  parameter int                STACK_D    = 4
) (
  input logic           clk,
  input logic           reset_n,
  microseq_ctrl_if.slave bus
);

  localparam logic [2:0] NS_DECODE = 3'd0;
  localparam logic [2:0] NS_FETCH  = 3'd1;
  localparam logic [2:0] NS_INC    = 3'd2;
  localparam logic [2:0] NS_BRANCH = 3'd3;
  localparam logic [2:0] NS_JUMP   = 3'd4;
  localparam logic [2:0] NS_CALL   = 3'd5;
  localparam logic [2:0] NS_RETURN = 3'd6;
  localparam logic [2:0] NS_WAIT   = 3'd7;

  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [ADDR_W-1:0] inc;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              mem_fault_q, mem_fault_d;
  logic              cond_raw;
  logic              cond;

`ifdef MICROSEQ_RETURN_STACK_EN
  localparam int SP_W = $clog2(STACK_D);
  logic [ADDR_W-1:0] stack_q [STACK_D];
  logic [ADDR_W-1:0] stack_d [STACK_D];
  logic [3:0]        depth_q, depth_d;
  logic [3:0]        depth_m1;
  logic              stack_err_q, stack_err_d;

  assign depth_m1 = depth_q - 4'd1;
`endif

  assign inc = upc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // cond_sel 0 is "always"; 7 is an unused slot that reads as false.
  always_comb begin
    cond_raw = 1'b0;
    case (bus.cond_sel)
      3'd0:    cond_raw = 1'b1;
      3'd7:    cond_raw = 1'b0;
      default: cond_raw = bus.cond_in[bus.cond_sel - 3'd1];
    endcase
    cond = cond_raw ^ bus.inv;
  end

  always_comb begin
    upc_d       = upc_q;
    wcnt_d      = 8'd0;
    mem_fault_d = 1'b0;
`ifdef MICROSEQ_RETURN_STACK_EN
    stack_d     = stack_q;
    depth_d     = depth_q;
    stack_err_d = stack_err_q;
`endif
    if (bus.stall) begin
      wcnt_d = wcnt_q;
    end else begin
      case (bus.ns)
        NS_DECODE: upc_d = bus.dec_addr;
        NS_FETCH:  upc_d = '0;
        NS_INC:    upc_d = inc;
        NS_BRANCH: upc_d = cond ? bus.cr_addr : inc;
        NS_JUMP:   upc_d = bus.cr_addr;
        NS_CALL: begin
          upc_d = bus.cr_addr;
`ifdef MICROSEQ_RETURN_STACK_EN
          // A full stack still takes the branch; only the return address is lost.
          if (depth_q == 4'(STACK_D)) begin
            stack_err_d = 1'b1;
          end else begin
            stack_d[depth_q[SP_W-1:0]] = inc;
            depth_d                    = depth_q + 4'd1;
          end
`endif
        end
        NS_RETURN: begin
`ifdef MICROSEQ_RETURN_STACK_EN
          if (depth_q == 4'd0) begin
            upc_d       = '0;
            stack_err_d = 1'b1;
          end else begin
            upc_d   = stack_q[depth_m1[SP_W-1:0]];
            depth_d = depth_m1;
          end
`else
          upc_d = '0;
`endif
        end
        NS_WAIT: begin
          // moc is checked first so a completion on the timeout cycle is honoured.
          if (bus.moc) begin
            upc_d = inc;
          end else if (wcnt_q == 8'(TIMEOUT - 1)) begin
            upc_d       = FAULT_ADDR;
            mem_fault_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
        default: upc_d = upc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upc_q       <= '0;
      wcnt_q      <= 8'd0;
      mem_fault_q <= 1'b0;
    end else begin
      upc_q       <= upc_d;
      wcnt_q      <= wcnt_d;
      mem_fault_q <= mem_fault_d;
    end
  end

`ifdef MICROSEQ_RETURN_STACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STACK_D; i++) stack_q[i] <= '0;
      depth_q     <= 4'd0;
      stack_err_q <= 1'b0;
    end else begin
      stack_q     <= stack_d;
      depth_q     <= depth_d;
      stack_err_q <= stack_err_d;
    end
  end

  assign bus.depth     = depth_q;
  assign bus.stack_err = stack_err_q;
`else
  assign bus.depth     = 4'd0;
  assign bus.stack_err = 1'b0;
`endif

  assign bus.index     = upc_q;
  assign bus.mem_fault = mem_fault_q;

endmodule

// File: tb/tb_microseq_ctrl.sv
// tb/tb_microseq_ctrl.sv - scoreboard bench for microseq_ctrl
module tb_microseq_ctrl;

  logic clk;
  logic reset_n;

  microseq_ctrl_if #(.ADDR_W(7)) bus ();

  microseq_ctrl #(
    .ADDR_W(7), .TIMEOUT(15), .FAULT_ADDR(7'h60), .STACK_D(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] idx;
    logic       mf;
    logic       se;
    logic [3:0] dep;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic se_x;

  task automatic push(input string nm, input logic [6:0] idx, input logic mf,
                      input logic se, input logic [3:0] dep);
    exp_t x;
    x.name = nm; x.idx = idx; x.mf = mf; x.se = se; x.dep = dep;
    sb_q.push_back(x);
  endtask

  task automatic tick(input string nm, input logic [6:0] idx, input logic mf,
                      input logic se, input logic [3:0] dep);
    @(posedge clk);
    push(nm, idx, mf, se, dep);
    @(negedge clk);
  endtask

  task automatic drv(input logic [2:0] ns, input logic [2:0] cs, input logic inv,
                     input logic [6:0] cr, input logic [6:0] dec, input logic moc,
                     input logic [5:0] cin, input logic st);
    bus.ns = ns; bus.cond_sel = cs; bus.inv = inv; bus.cr_addr = cr;
    bus.dec_addr = dec; bus.moc = moc; bus.cond_in = cin; bus.stall = st;
  endtask

  // Monitor: every cycle the sequencer presents a new index; compare against
  // the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (bus.index !== e.idx || bus.mem_fault !== e.mf ||
            bus.stack_err !== e.se || bus.depth !== e.dep) begin
          n_fail++;
          $display("FAIL %s: got index=%h mem_fault=%b stack_err=%b depth=%0d, expected index=%h mem_fault=%b stack_err=%b depth=%0d",
                   e.name, bus.index, bus.mem_fault, bus.stack_err, bus.depth,
                   e.idx, e.mf, e.se, e.dep);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    drv(3'd2, 3'd0, 1'b0, 7'h00, 7'h00, 1'b0, 6'b0, 1'b0);
    #3 push("reset", 7'h00, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;

    tick("inc1", 7'h01, 0, 0, 0);
    tick("inc2", 7'h02, 0, 0, 0);
    tick("inc3", 7'h03, 0, 0, 0);
    drv(3'd0, 3'd0, 0, 7'h00, 7'h2D, 0, 6'b0, 0);         tick("decode", 7'h2D, 0, 0, 0);
    drv(3'd4, 3'd0, 0, 7'h10, 7'h00, 0, 6'b0, 0);         tick("jump_10", 7'h10, 0, 0, 0);
    drv(3'd3, 3'd3, 0, 7'h55, 7'h00, 0, 6'b000100, 0);    tick("br_z_taken", 7'h55, 0, 0, 0);
    drv(3'd4, 3'd0, 0, 7'h10, 7'h00, 0, 6'b0, 0);         tick("jump_back", 7'h10, 0, 0, 0);
    drv(3'd3, 3'd3, 1, 7'h55, 7'h00, 0, 6'b000100, 0);    tick("br_z_inv", 7'h11, 0, 0, 0);
    drv(3'd3, 3'd7, 0, 7'h30, 7'h00, 0, 6'b111111, 0);    tick("br_sel7", 7'h12, 0, 0, 0);
    drv(3'd3, 3'd7, 1, 7'h30, 7'h00, 0, 6'b000000, 0);    tick("br_sel7_inv", 7'h30, 0, 0, 0);
    drv(3'd3, 3'd0, 0, 7'h40, 7'h00, 0, 6'b000000, 0);    tick("br_always", 7'h40, 0, 0, 0);
    drv(3'd3, 3'd4, 0, 7'h70, 7'h00, 0, 6'b000100, 0);    tick("br_n_clear", 7'h41, 0, 0, 0);
    drv(3'd3, 3'd6, 0, 7'h70, 7'h00, 0, 6'b100000, 0);    tick("br_v_set", 7'h70, 0, 0, 0);
    drv(3'd4, 3'd0, 0, 7'h7F, 7'h00, 0, 6'b0, 0);         tick("jump_7f", 7'h7F, 0, 0, 0);
    drv(3'd2, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);         tick("wrap", 7'h00, 0, 0, 0);
    drv(3'd4, 3'd0, 0, 7'h20, 7'h00, 0, 6'b0, 0);         tick("jump_20", 7'h20, 0, 0, 0);

`ifdef MICROSEQ_RETURN_STACK_EN
    drv(3'd5, 3'd0, 0, 7'h50, 7'h00, 0, 6'b0, 0);         tick("call", 7'h50, 0, 0, 1);
    drv(3'd6, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);         tick("ret", 7'h21, 0, 0, 0);
    drv(3'd5, 3'd0, 0, 7'h10, 7'h00, 0, 6'b0, 0);         tick("call1", 7'h10, 0, 0, 1);
    drv(3'd5, 3'd0, 0, 7'h11, 7'h00, 0, 6'b0, 0);         tick("call2", 7'h11, 0, 0, 2);
    drv(3'd5, 3'd0, 0, 7'h12, 7'h00, 0, 6'b0, 0);         tick("call3", 7'h12, 0, 0, 3);
    drv(3'd5, 3'd0, 0, 7'h13, 7'h00, 0, 6'b0, 0);         tick("call4", 7'h13, 0, 0, 4);
    drv(3'd5, 3'd0, 0, 7'h14, 7'h00, 0, 6'b0, 0);         tick("call_ovf", 7'h14, 0, 1, 4);
    drv(3'd6, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);
    tick("ret4", 7'h13, 0, 1, 3);
    tick("ret3", 7'h12, 0, 1, 2);
    tick("ret2", 7'h11, 0, 1, 1);
    tick("ret1", 7'h22, 0, 1, 0);
    tick("ret_unf", 7'h00, 0, 1, 0);
    se_x = 1'b1;
`else
    drv(3'd5, 3'd0, 0, 7'h50, 7'h00, 0, 6'b0, 0);         tick("call_as_jump", 7'h50, 0, 0, 0);
    drv(3'd6, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);         tick("ret_as_fetch", 7'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drv(3'd5, 3'd0, 0, 7'(7'h10 + i), 7'h00, 0, 6'b0, 0);
      tick("call_nest", 7'(7'h10 + i), 0, 0, 0);
    end
    drv(3'd6, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);         tick("ret_nest", 7'h00, 0, 0, 0);
    se_x = 1'b0;
`endif

    // Memory wait completing after three held cycles.
    drv(3'd4, 3'd0, 0, 7'h05, 7'h00, 0, 6'b0, 0);         tick("jump_05", 7'h05, 0, se_x, 0);
    drv(3'd7, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);
    for (int i = 0; i < 3; i++) tick("wait_hold", 7'h05, 0, se_x, 0);
    drv(3'd7, 3'd0, 0, 7'h00, 7'h00, 1, 6'b0, 0);         tick("wait_done", 7'h06, 0, se_x, 0);

    // Timeout: 14 held cycles, fault on the 15th.
    drv(3'd7, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);
    for (int i = 0; i < 14; i++) tick("to_hold", 7'h06, 0, se_x, 0);
    tick("timeout", 7'h60, 1, se_x, 0);
    drv(3'd2, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);         tick("fault_pulse_end", 7'h61, 0, se_x, 0);

    // moc on the timeout cycle wins.
    drv(3'd4, 3'd0, 0, 7'h30, 7'h00, 0, 6'b0, 0);         tick("jump_30", 7'h30, 0, se_x, 0);
    drv(3'd7, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);
    for (int i = 0; i < 14; i++) tick("race_hold", 7'h30, 0, se_x, 0);
    drv(3'd7, 3'd0, 0, 7'h00, 7'h00, 1, 6'b0, 0);         tick("moc_wins", 7'h31, 0, se_x, 0);

    // Stall mid-wait freezes the wait counter.
    drv(3'd7, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);
    for (int i = 0; i < 5; i++) tick("pre_stall", 7'h31, 0, se_x, 0);
    drv(3'd7, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 1);
    for (int i = 0; i < 5; i++) tick("stall_hold", 7'h31, 0, se_x, 0);
    drv(3'd7, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);
    for (int i = 0; i < 9; i++) tick("post_stall", 7'h31, 0, se_x, 0);
    tick("stall_timeout", 7'h60, 1, se_x, 0);

    // Asynchronous reset in the middle of a wait.
    drv(3'd2, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);         tick("inc_61", 7'h61, 0, se_x, 0);
    drv(3'd7, 3'd0, 0, 7'h00, 7'h00, 0, 6'b0, 0);
    for (int i = 0; i < 3; i++) tick("wait_61", 7'h61, 0, se_x, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    push("async_reset", 7'h00, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) tick("rst_wcnt_hold", 7'h00, 0, 0, 0);
    tick("rst_wcnt_timeout", 7'h60, 1, 0, 0);

    #1;
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/microseq_ctrl.md
# microseq_ctrl

Microsequencer for the control unit. It generates the 7-bit index into the 45-bit microstore each cycle from next-state fields taken from the current microinstruction, the instruction decoder's entry address and the status/condition inputs. It sits between the control register (the latched microstore output) and the microstore address input. It provides increment, decode dispatch, conditional branch, call/return and memory-wait sequencing, with a timeout on memory waits.

## Interface
- `ADDR_W`, default 7: microstore address width.
- `TIMEOUT`, default 15: maximum cycles spent in a memory wait before faulting (1..255).
- `FAULT_ADDR`, default 7'h60: address the sequencer jumps to on a memory-wait timeout.
- `STACK_D`, default 4: return stack depth (power of two, 2..8).

Ports:
- `clk` (in, 1): clock, rising edge.
- `reset_n` (in, 1): asynchronous, active-low reset.
- `stall` (in, 1): freezes all sequencer state.
- `ns` (in, 3): next-state mode from the control register.
- `cond_sel` (in, 3): condition select.
- `inv` (in, 1): inverts the selected condition.
- `cr_addr` (in, ADDR_W): branch/jump/call target from the control register.
- `dec_addr` (in, ADDR_W): entry address from the instruction decoder.
- `moc` (in, 1): memory operation complete.
- `cond_in` (in, 6): {V,C,N,Z,cond_pass,moc_alt} for cond_sel 6..1.
- `index` (out, ADDR_W): registered microstore address.
- `mem_fault` (out, 1): one-cycle pulse on wait timeout.
- `stack_err` (out, 1): sticky; set on stack overflow or underflow.
- `depth` (out, 4): current return-stack occupancy.

## Operation
- Internal microPC is `upc`; `index` = `upc`. `inc` = `upc`+1 mod 2^ADDR_W, so 7'h7F wraps to 0.
- Condition `c` = (`cond_sel`==0 ? 1 : `cond_in[cond_sel-1]`) XOR `inv`. `cond_sel`==7 is treated as constant 0 (before `inv`).
- Next address by `ns`:
  - 000 decode: `dec_addr`.
  - 001 fetch: 0.
  - 010 increment: `inc`.
  - 011 conditional branch: `c` ? `cr_addr` : `inc`.
  - 100 jump: `cr_addr`.
  - 101 call: push `inc`, then go to `cr_addr`.
  - 110 return: pop into `upc`.
  - 111 memory wait: hold `upc` until `moc`=1, then go to `inc`.
- Wait counter `wcnt` (8 bit):
  - Cleared whenever `ns`≠111 or `moc`=1.
  - Increments on each held wait cycle.
  - When `wcnt` reaches TIMEOUT-1 with `moc` still 0: next = FAULT_ADDR, `mem_fault` pulses, `wcnt` clears.
  - `moc` and timeout in the same cycle: `moc` wins, next = `inc`.
- Stack overflow (call at `depth`==STACK_D): target is still taken, the push is dropped, `stack_err` is set.
- Stack underflow (return at `depth`==0): next = 0, `stack_err` is set.
- `stall`=1 holds `upc`, `wcnt`, the stack and `depth`, and suppresses `mem_fault`. Stall has priority over every mode.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - `upc`=0, so `index`=0;
  - `wcnt`=0, `depth`=0, stack contents 0;
  - `mem_fault`=0, `stack_err`=0.
- First edge after reset release: the control register holds ROM[0]. The sequencer acts on its fields at that edge.
- Latency: the fields present before edge k determine `index` after edge k, i.e. one cycle per microinstruction.
- Mode, condition, `moc` and stall are sampled only at the rising edge. Inputs must be stable during setup.
- `mem_fault` is registered, high for exactly the one cycle in which `index`=FAULT_ADDR first appears.
- Reset asserted mid-wait or mid-call abandons all state immediately.

## Configuration
- `MICROSEQ_RETURN_STACK_EN` defined: call/return and the return stack operate as described, and `depth` reports occupancy.
- `MICROSEQ_RETURN_STACK_EN` undefined:
  - No stack storage.
  - 101 behaves as 100 (jump).
  - 110 behaves as 001 (fetch to 0).
  - `depth` is tied to 0 and `stack_err` never sets.

## Test plan
- Reset release with `ns`=010 for 3 cycles -> `index` 0, 1, 2, 3. Then `ns`=000 with `dec_addr`=7'h2D -> `index`=7'h2D.
- `upc`=7'h10, `ns`=011, `cond_sel`=3, Z=1, `inv`=0, `cr_addr`=7'h55 -> `index`=7'h55. Same with `inv`=1 -> `index`=7'h11.
- Call from 7'h20 to 7'h50, then return -> `index` 7'h50 then 7'h21, `depth` 1 then 0. Five nested calls with STACK_D=4 -> `stack_err`=1, `depth`=4. Without the macro, return -> `index`=0.
- `ns`=111 at 7'h05 with `moc` low 3 cycles then high -> `index` holds 7'h05 for 4 cycles, then 7'h06, `mem_fault`=0.
- `ns`=111 with `moc` never asserting, TIMEOUT=15 -> after 15 cycles `index`=7'h60 and `mem_fault` high for exactly 1 cycle.
- `stall`=1 for 5 cycles during a wait -> `index` and `wcnt` unchanged. `reset_n` low mid-wait -> `index`=0 immediately, no `mem_fault`.
